// File: rtl/cu_pkg.sv
// Shared encodings for the multi-cycle control unit: states, opcodes, ALU/PC selects and the control vector.
package cu_pkg;

  localparam int unsigned OP_W    = 6;
  localparam int unsigned ALUOP_W = 3;
  localparam int unsigned PCSRC_W = 2;
  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IF     = 3'b000,
    S_ID     = 3'b001,
    S_EXE_LS = 3'b010,
    S_MEM    = 3'b011,
    S_WB_LD  = 3'b100,
    S_EXE_BR = 3'b101,
    S_EXE_AL = 3'b110,
    S_WB_AL  = 3'b111
  } state_e;

  localparam logic [OP_W-1:0] OP_ADD  = 6'b000000;
  localparam logic [OP_W-1:0] OP_SUB  = 6'b000001;
  localparam logic [OP_W-1:0] OP_ADDI = 6'b000010;
  localparam logic [OP_W-1:0] OP_OR   = 6'b010000;
  localparam logic [OP_W-1:0] OP_AND  = 6'b010001;
  localparam logic [OP_W-1:0] OP_ORI  = 6'b010010;
  localparam logic [OP_W-1:0] OP_SLL  = 6'b011000;
  localparam logic [OP_W-1:0] OP_SLTI = 6'b100111;
  localparam logic [OP_W-1:0] OP_SW   = 6'b110000;
  localparam logic [OP_W-1:0] OP_LW   = 6'b110001;
  localparam logic [OP_W-1:0] OP_BEQ  = 6'b110100;
  localparam logic [OP_W-1:0] OP_BNE  = 6'b110101;
  localparam logic [OP_W-1:0] OP_J    = 6'b111000;
  localparam logic [OP_W-1:0] OP_JR   = 6'b111001;
  localparam logic [OP_W-1:0] OP_JAL  = 6'b111010;
  localparam logic [OP_W-1:0] OP_HALT = 6'b111111;

  localparam logic [ALUOP_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALUOP_W-1:0] ALU_SUB = 3'b001;
  localparam logic [ALUOP_W-1:0] ALU_SLL = 3'b010;
  localparam logic [ALUOP_W-1:0] ALU_OR  = 3'b011;
  localparam logic [ALUOP_W-1:0] ALU_AND = 3'b100;
  localparam logic [ALUOP_W-1:0] ALU_SLT = 3'b110;

  localparam logic [PCSRC_W-1:0] PC_SEQ    = 2'b00;
  localparam logic [PCSRC_W-1:0] PC_BRANCH = 2'b01;
  localparam logic [PCSRC_W-1:0] PC_JR     = 2'b10;
  localparam logic [PCSRC_W-1:0] PC_JUMP   = 2'b11;

  localparam logic [1:0] RD_RA = 2'b00;
  localparam logic [1:0] RD_RT = 2'b01;
  localparam logic [1:0] RD_RD = 2'b10;

  typedef struct packed {
    logic               pc_wre;
    logic [PCSRC_W-1:0] pc_src;
    logic               ir_wre;
    logic               ins_mem_rw;
    logic               reg_wre;
    logic [1:0]         reg_dst;
    logic               wr_reg_d_src;
    logic               alu_src_a;
    logic               alu_src_b;
    logic [ALUOP_W-1:0] alu_op;
    logic               ext_sel;
    logic               m_rd;
    logic               m_wr;
    logic               db_data_src;
  } ctrl_t;

  function automatic logic is_rtype(input logic [OP_W-1:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_OR) ||
           (op == OP_AND) || (op == OP_SLL);
  endfunction

  function automatic logic is_alu(input logic [OP_W-1:0] op);
    return is_rtype(op) || (op == OP_ADDI) || (op == OP_ORI) || (op == OP_SLTI);
  endfunction

endpackage

// File: rtl/cu_decode.sv
// Combinational decode of (state, opcode, zero, memory-go) into the datapath control vector.
module cu_decode
  import cu_pkg::*;
(
  input  state_e            state_i,
  input  logic [OP_W-1:0]   op_i,
  input  logic              zero_i,
  input  logic              mem_go_i,
  output ctrl_t             ctrl_o
);

  always_comb begin
    ctrl_o            = '0;
    ctrl_o.ins_mem_rw = 1'b1;

    // Operand/ALU selects follow the opcode once the IR holds it (every state but IF).
    if (state_i != S_IF) begin
      case (op_i)
        OP_ADD:       ctrl_o.alu_op = ALU_ADD;
        OP_SUB:       ctrl_o.alu_op = ALU_SUB;
        OP_OR:        ctrl_o.alu_op = ALU_OR;
        OP_AND:       ctrl_o.alu_op = ALU_AND;
        OP_SLL: begin ctrl_o.alu_op = ALU_SLL; ctrl_o.alu_src_a = 1'b1; end
        OP_ADDI: begin
          ctrl_o.alu_op = ALU_ADD; ctrl_o.alu_src_b = 1'b1; ctrl_o.ext_sel = 1'b1;
        end
        OP_ORI:  begin ctrl_o.alu_op = ALU_OR; ctrl_o.alu_src_b = 1'b1; end
        OP_SLTI: begin
          ctrl_o.alu_op = ALU_SLT; ctrl_o.alu_src_b = 1'b1; ctrl_o.ext_sel = 1'b1;
        end
        OP_LW, OP_SW: begin
          ctrl_o.alu_op = ALU_ADD; ctrl_o.alu_src_b = 1'b1; ctrl_o.ext_sel = 1'b1;
        end
        OP_BEQ, OP_BNE: begin ctrl_o.alu_op = ALU_SUB; ctrl_o.ext_sel = 1'b1; end
        default: ;
      endcase
    end

    case (state_i)
      S_IF: ctrl_o.ir_wre = 1'b1;
      S_ID: begin
        case (op_i)
          OP_J:  begin ctrl_o.pc_wre = 1'b1; ctrl_o.pc_src = PC_JUMP; end
          OP_JR: begin ctrl_o.pc_wre = 1'b1; ctrl_o.pc_src = PC_JR; end
          OP_JAL: begin
            ctrl_o.pc_wre  = 1'b1;
            ctrl_o.pc_src  = PC_JUMP;
            ctrl_o.reg_wre = 1'b1;
            ctrl_o.reg_dst = RD_RA;
          end
          OP_HALT, OP_BEQ, OP_BNE, OP_LW, OP_SW: ;
          default: ctrl_o.pc_wre = !is_alu(op_i);
        endcase
      end
      S_EXE_BR: begin
        ctrl_o.pc_wre = 1'b1;
        if (((op_i == OP_BEQ) && zero_i) || ((op_i == OP_BNE) && !zero_i))
          ctrl_o.pc_src = PC_BRANCH;
      end
      S_MEM: begin
        ctrl_o.m_rd   = (op_i == OP_LW);
        ctrl_o.m_wr   = (op_i == OP_SW);
        ctrl_o.pc_wre = (op_i == OP_SW) && mem_go_i;
      end
      S_WB_LD: begin
        ctrl_o.pc_wre       = 1'b1;
        ctrl_o.reg_wre      = 1'b1;
        ctrl_o.reg_dst      = RD_RT;
        ctrl_o.wr_reg_d_src = 1'b1;
        ctrl_o.db_data_src  = 1'b1;
      end
      S_WB_AL: begin
        ctrl_o.pc_wre       = 1'b1;
        ctrl_o.reg_wre      = 1'b1;
        ctrl_o.reg_dst      = is_rtype(op_i) ? RD_RD : RD_RT;
        ctrl_o.wr_reg_d_src = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle CPU controller: state register and next-state sequencing IF/ID/EXE/MEM/WB.
// MULTICYCLE_MEM_WAIT_EN: when defined, S_MEM stalls until mem_ready is high.
module multicycle_control_unit
  import cu_pkg::*;
(
  input  logic               clk,
  input  logic               Reset,
  input  logic [OP_W-1:0]    op,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               PCWre,
  output logic [PCSRC_W-1:0] PCSrc,
  output logic               IRWre,
  output logic               InsMemRW,
  output logic               RegWre,
  output logic [1:0]         RegDst,
  output logic               WrRegDSrc,
  output logic               ALUSrcA,
  output logic               ALUSrcB,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               ExtSel,
  output logic               mRD,
  output logic               mWR,
  output logic               DBDataSrc,
  output logic [STATE_W-1:0] state
);

  state_e state_q, state_d;
  logic   mem_go;
  ctrl_t  ctrl;

`ifdef MULTICYCLE_MEM_WAIT_EN
  assign mem_go = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_go           = 1'b1;
`endif

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) state_q <= S_IF;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IF: state_d = S_ID;
      S_ID: begin
        case (op)
          OP_J, OP_JR, OP_JAL: state_d = S_IF;
          OP_HALT:             state_d = S_ID;
          OP_BEQ, OP_BNE:      state_d = S_EXE_BR;
          OP_LW, OP_SW:        state_d = S_EXE_LS;
          default:             state_d = is_alu(op) ? S_EXE_AL : S_IF;
        endcase
      end
      S_EXE_LS: state_d = S_MEM;
      S_MEM:    if (mem_go) state_d = (op == OP_LW) ? S_WB_LD : S_IF;
      S_EXE_AL: state_d = S_WB_AL;
      S_EXE_BR, S_WB_AL, S_WB_LD: state_d = S_IF;
      default:  state_d = S_IF;
    endcase
  end

  cu_decode u_decode (
    .state_i  (state_q),
    .op_i     (op),
    .zero_i   (zero),
    .mem_go_i (mem_go),
    .ctrl_o   (ctrl)
  );

  assign PCWre     = ctrl.pc_wre;
  assign PCSrc     = ctrl.pc_src;
  assign IRWre     = ctrl.ir_wre;
  assign InsMemRW  = ctrl.ins_mem_rw;
  assign RegWre    = ctrl.reg_wre;
  assign RegDst    = ctrl.reg_dst;
  assign WrRegDSrc = ctrl.wr_reg_d_src;
  assign ALUSrcA   = ctrl.alu_src_a;
  assign ALUSrcB   = ctrl.alu_src_b;
  assign ALUOp     = ctrl.alu_op;
  assign ExtSel    = ctrl.ext_sel;
  assign mRD       = ctrl.m_rd;
  assign mWR       = ctrl.m_wr;
  assign DBDataSrc = ctrl.db_data_src;
  assign state     = STATE_W'(state_q);

endmodule
